// File: rtl/rst_request_gen.sv
// -----------------------------------------------------------------------------
// rst_request_gen
//
// Source side of the system reset path. Collects reset requests from a raw
// push-button, a keyed software write and an optional watchdog, and drives one
// clean, stretched, active-high request into the reset controller's rst_in.
// The request is held for at least REQ_CYCLES clocks and for as long as the
// debounced button stays pressed. A sticky cause register records which
// source(s) requested a reset.
//
// This block must be reset by power-on reset only, never by the reset it
// requests, otherwise the cause register would be wiped by its own request.
//
// Optional feature macro: RSTREQ_WDT_EN
//   defined   : watchdog counter and cause[2] are implemented.
//   undefined : no watchdog logic, wdt_en/wdt_kick ignored, cause[2] = 0,
//               WDT_CYCLES unused.
//
// Ports:
//   clk        in   1  free-running system clock
//   rst        in   1  synchronous active-high reset (power-on only)
//   btn_in     in   1  raw asynchronous button, active level = BTN_POLAR
//   sw_we      in   1  software reset write strobe (one-cycle pulse)
//   sw_key     in   8  key data sampled with sw_we
//   wdt_en     in   1  watchdog enable level
//   wdt_kick   in   1  watchdog service pulse
//   cause_clr  in   1  clears the cause register
//   rst_req    out  1  active-high reset request to the controller
//   cause      out  3  sticky cause: bit0 button, bit1 software, bit2 watchdog
// -----------------------------------------------------------------------------
module rst_request_gen #(
    parameter bit         BTN_POLAR       = 1'b0,
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter int         REQ_CYCLES      = 8,
    parameter int         WDT_CYCLES      = 1024,
    parameter logic [7:0] SW_KEY          = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    input  logic       sw_we,
    input  logic [7:0] sw_key,
    input  logic       wdt_en,
    input  logic       wdt_kick,
    input  logic       cause_clr,
    output logic       rst_req,
    output logic [2:0] cause
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = $clog2(REQ_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(REQ_CYCLES - 1);

    // Raw-pin level that means "button released".
    localparam logic BTN_IDLE = !BTN_POLAR;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Button: 2-FF synchronizer and debounce
    // ------------------------------------------------------------------
    logic            btn_meta;
    logic            btn_sync;
    logic            btn_act;     // synchronized level, 1 = pressed
    logic            btn_db;      // debounced state, 1 = pressed
    logic [DB_W-1:0] db_cnt;
    logic            btn_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta <= BTN_IDLE;
            btn_sync <= BTN_IDLE;
        end else begin
            btn_meta <= btn_in;
            btn_sync <= btn_meta;
        end
    end

    assign btn_act = (btn_sync == BTN_POLAR);

    // Counter only runs while the synchronized level disagrees with the
    // accepted state; any agreeing sample restarts the stability window.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (btn_act != btn_db) begin
            if (db_cnt == DB_MAX) begin
                btn_db <= btn_act;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // Press edge only: the flip that is about to make btn_db active.
    assign btn_evt = btn_act && !btn_db && (db_cnt == DB_MAX);

    // ------------------------------------------------------------------
    // Software request: wrong key is silently dropped
    // ------------------------------------------------------------------
    logic sw_evt;

    assign sw_evt = sw_we && (sw_key == SW_KEY);

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    logic wdt_evt;

`ifdef RSTREQ_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt;

    // A kick in the terminal cycle wins; the counter is also frozen at zero
    // while a request is outstanding so the system gets a full timeout after
    // coming out of reset.
    assign wdt_evt = wdt_en && !wdt_kick && !rst_req && (wdt_cnt == WDT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt <= '0;
        end else if (!wdt_en || wdt_kick || rst_req || wdt_evt) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + WDT_W'(1);
        end
    end
`else
    localparam int WDT_CYCLES_UNUSED = WDT_CYCLES;

    logic wdt_inputs_unused;

    assign wdt_inputs_unused = wdt_en | wdt_kick;
    assign wdt_evt           = 1'b0;
`endif

    logic [2:0] evt_vec;
    logic       any_evt;

    assign evt_vec = {wdt_evt, sw_evt, btn_evt};
    assign any_evt = |evt_vec;

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            rst_req  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    rst_req <= 1'b0;
                    if (any_evt) begin
                        state    <= S_ASSERT;
                        hold_cnt <= '0;
                        rst_req  <= 1'b1;
                    end
                end
                S_ASSERT: begin
                    rst_req <= 1'b1;
                    if (hold_cnt == HOLD_MAX) begin
                        // Skip the RELEASE wait entirely when the button is
                        // already up so the minimum-width pulse ends on time.
                        if (btn_db) begin
                            state <= S_RELEASE;
                        end else begin
                            state   <= S_IDLE;
                            rst_req <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (btn_db) begin
                        rst_req <= 1'b1;
                    end else begin
                        state   <= S_IDLE;
                        rst_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    rst_req <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Cause register: set beats clear, bits sticky
    // ------------------------------------------------------------------
    logic [2:0] cause_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cause_q <= '0;
        end else begin
            cause_q <= (cause_clr ? 3'b000 : cause_q) | evt_vec;
        end
    end

    assign cause = cause_q;

endmodule

// File: tb/tb_rst_request_gen.sv
module tb_rst_request_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_in;
    logic       sw_we;
    logic [7:0] sw_key;
    logic       wdt_en;
    logic       wdt_kick;
    logic       cause_clr;
    logic       rst_req;
    logic [2:0] cause;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic       req;
        logic [2:0] cse;
    } exp_t;

    exp_t sb[$];

    rst_request_gen #(
        .BTN_POLAR       (1'b0),
        .DEBOUNCE_CYCLES (16),
        .REQ_CYCLES      (8),
        .WDT_CYCLES      (64),
        .SW_KEY          (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .sw_we     (sw_we),
        .sw_key    (sw_key),
        .wdt_en    (wdt_en),
        .wdt_kick  (wdt_kick),
        .cause_clr (cause_clr),
        .rst_req   (rst_req),
        .cause     (cause)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    // Queue n cycles of expected outputs (one entry per coming clock edge).
    task automatic expect_cycles(input string tag, input int n, input logic req, input logic [2:0] cse);
        exp_t e;
        e.tag = tag;
        e.req = req;
        e.cse = cse;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    // Advance one edge per queued entry and compare #1 after that edge.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            assert ({rst_req, cause} === {e.req, e.cse}) else begin
                errors++;
                $error("FAIL %s: rst_req/cause observed=%0b/%03b expected=%0b/%03b",
                       e.tag, rst_req, cause, e.req, e.cse);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        btn_in    = 1'b1;   // active-low button released
        sw_we     = 1'b0;
        sw_key    = 8'h00;
        wdt_en    = 1'b0;
        wdt_kick  = 1'b0;
        cause_clr = 1'b0;

        // Reset state
        expect_cycles("reset", 3, 1'b0, 3'b000);
        drain();
        rst = 1'b0;
        expect_cycles("idle", 4, 1'b0, 3'b000);
        drain();

        // Glitch shorter than the debounce window is ignored
        btn_in = 1'b0;
        expect_cycles("glitch", 10, 1'b0, 3'b000);
        drain();
        btn_in = 1'b1;
        expect_cycles("glitch_after", 30, 1'b0, 3'b000);
        drain();

        // Press for 40 cycles: 2 sync + 16 debounce -> request after edge 18,
        // held while pressed, drops one cycle after the debounced release.
        btn_in = 1'b0;
        expect_cycles("press_wait", 17, 1'b0, 3'b000);
        expect_cycles("press_req", 23, 1'b1, 3'b001);
        drain();
        btn_in = 1'b1;
        expect_cycles("release_hold", 18, 1'b1, 3'b001);
        expect_cycles("release_done", 20, 1'b0, 3'b001);
        drain();
        cause_clr = 1'b1;
        expect_cycles("clr_btn", 1, 1'b0, 3'b000);
        drain();
        cause_clr = 1'b0;

        // Software write with wrong key: no effect
        sw_we  = 1'b1;
        sw_key = 8'h5A;
        expect_cycles("sw_badkey", 1, 1'b0, 3'b000);
        drain();
        sw_we = 1'b0;
        expect_cycles("sw_badkey_after", 5, 1'b0, 3'b000);
        drain();

        // Correct key: exactly 8 cycles of request
        sw_we  = 1'b1;
        sw_key = 8'hA5;
        expect_cycles("sw_req_first", 1, 1'b1, 3'b010);
        drain();
        sw_we = 1'b0;
        expect_cycles("sw_req_hold", 7, 1'b1, 3'b010);
        expect_cycles("sw_req_end", 5, 1'b0, 3'b010);
        drain();
        cause_clr = 1'b1;
        expect_cycles("clr_sw", 1, 1'b0, 3'b000);
        drain();
        cause_clr = 1'b0;

        // Button request, then software event together with cause_clr while
        // the request is active: width unchanged, set beats clear.
        btn_in = 1'b0;
        expect_cycles("sim_wait", 17, 1'b0, 3'b000);
        expect_cycles("sim_req", 2, 1'b1, 3'b001);
        drain();
        sw_we     = 1'b1;
        sw_key    = 8'hA5;
        cause_clr = 1'b1;
        expect_cycles("sim_setclr", 1, 1'b1, 3'b010);
        drain();
        sw_we     = 1'b0;
        cause_clr = 1'b0;
        expect_cycles("sim_held", 20, 1'b1, 3'b010);
        drain();
        btn_in = 1'b1;
        expect_cycles("sim_release_hold", 18, 1'b1, 3'b010);
        expect_cycles("sim_release_done", 10, 1'b0, 3'b010);
        drain();
        cause_clr = 1'b1;
        expect_cycles("clr_sim", 1, 1'b0, 3'b000);
        drain();
        cause_clr = 1'b0;

        // rst in the middle of a request
        sw_we  = 1'b1;
        sw_key = 8'hA5;
        expect_cycles("mid_req1", 1, 1'b1, 3'b010);
        drain();
        sw_we = 1'b0;
        expect_cycles("mid_req2", 1, 1'b1, 3'b010);
        drain();
        rst = 1'b1;
        expect_cycles("mid_rst", 1, 1'b0, 3'b000);
        drain();
        rst = 1'b0;
        expect_cycles("mid_after", 10, 1'b0, 3'b000);
        drain();
        // FSM back in IDLE: a fresh request has full width
        sw_we = 1'b1;
        expect_cycles("post_rst_req1", 1, 1'b1, 3'b010);
        drain();
        sw_we = 1'b0;
        expect_cycles("post_rst_hold", 7, 1'b1, 3'b010);
        expect_cycles("post_rst_end", 3, 1'b0, 3'b010);
        drain();
        cause_clr = 1'b1;
        expect_cycles("clr_post", 1, 1'b0, 3'b000);
        drain();
        cause_clr = 1'b0;

`ifdef RSTREQ_WDT_EN
        // Regular kicks every 50 cycles keep the watchdog quiet
        wdt_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wdt_kick = 1'b1;
            expect_cycles("wdt_kick", 1, 1'b0, 3'b000);
            drain();
            wdt_kick = 1'b0;
            expect_cycles("wdt_kicked", 49, 1'b0, 3'b000);
            drain();
        end
        // Last kick: counter 0 after that edge, reaches 63 after 63 edges,
        // request visible on the 64th edge.
        wdt_kick = 1'b1;
        expect_cycles("wdt_last_kick", 1, 1'b0, 3'b000);
        drain();
        wdt_kick = 1'b0;
        expect_cycles("wdt_count", 63, 1'b0, 3'b000);
        expect_cycles("wdt_req", 8, 1'b1, 3'b100);
        expect_cycles("wdt_end", 10, 1'b0, 3'b100);
        drain();
        wdt_en = 1'b0;
        expect_cycles("wdt_off", 5, 1'b0, 3'b100);
        drain();
`else
        // Watchdog not built: enabled and never kicked, nothing happens
        wdt_en = 1'b1;
        expect_cycles("wdt_absent", 200, 1'b0, 3'b000);
        drain();
        wdt_en = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
